mem_seq: RTL
============

# mem_seq

Memory-access sequencer and bus arbiter for the MOSby core. It sits between the CPU control unit, a DMA requester and the single 8-bit memory port. It runs each CPU memory transaction as a fixed cycle sequence: opcode fetch, or operand-low / operand-high / data access for absolute mode. It interleaves DMA bursts with a starvation guard.

## Interface
Parameters:
- DMA_MAX_BURST, 4: maximum consecutive DMA cycles per grant (1..15).

Ports:
- clk_1  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- pc  in  16  CPU program counter; sampled on accept.
- cpu_req  in  1  CPU request valid; held until accepted.
- cpu_op  in  2  operation code:
  - 00 opcode fetch
  - 01 absolute read
  - 10 absolute write
  - 11 treated as fetch
- cpu_zp  in  1  zero-page modifier for ops 01/10; see Configuration.
- cpu_wdata  in  8  write data; sampled on accept.
- cpu_rdy  out  1  CPU request will be accepted this cycle.
- cpu_done  out  1  one-cycle pulse; CPU transaction complete.
- rd_data  out  8  last read byte (CPU or DMA).
- eff_addr  out  16  latched effective address of the last absolute op.
- dma_req  in  1  DMA request, level.
- dma_addr  in  16  DMA address.
- dma_we  in  1  DMA write enable.
- dma_wdata  in  8  DMA write data.
- dma_gnt  out  1  current cycle is a DMA access.
- dma_rvalid  out  1  pulse; rd_data holds a DMA read byte.
- mem_addr  out  16  memory address.
- mem_we  out  1  memory write strobe.
- mem_wdata  out  8  memory write data.
- mem_rdata  in  8  memory read data; single-cycle memory, valid in the same cycle as mem_addr.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, FETCH, ADL, ADH, DATA, DMA.
- IDLE decision, in priority order:
  - dma_req && (dma_turn || !cpu_req) → DMA.
  - else cpu_req → accept.
- cpu_rdy = IDLE && !(dma_req && dma_turn).
- Accepting a request latches pc into pc_q, plus cpu_op and cpu_wdata.
- If dma_req is high at accept, set dma_turn. Entering DMA clears dma_turn.
- FETCH: mem_addr = pc_q. rd_data <= mem_rdata. Return to IDLE and pulse cpu_done.
- ADL: mem_addr = pc_q + 1. Capture lo byte. Go to ADH.
- ADH: mem_addr = pc_q + 2. Capture hi byte. Go to DATA.
- Operand addresses are 16-bit and wrap: pc_q = 0xFFFF gives ADL at 0x0000 and ADH at 0x0001.
- DATA: mem_addr = {hi, lo}, which is also latched into eff_addr.
  - op 10: mem_we = 1 and mem_wdata = wdata_q.
  - op 01: rd_data <= mem_rdata.
  - Then go to IDLE and pulse cpu_done.
- DMA: each cycle drives mem_addr, mem_we and mem_wdata from the dma_* inputs, and dma_gnt = 1.
  - A read captures rd_data and pulses dma_rvalid in the next cycle.
  - Burst counter resets on entry. Exit to IDLE when dma_req falls or after DMA_MAX_BURST cycles.
- CPU transactions are atomic; DMA never preempts ADL/ADH/DATA.
- In IDLE: mem_addr = 0x0000, mem_we = 0, dma_gnt = 0.

## Timing
- Fetch latency: accept edge → FETCH cycle → cpu_done high in the following cycle (IDLE), with rd_data valid.
- Absolute latency: accept → ADL → ADH → DATA → cpu_done in the 4th cycle after accept.
- Back-to-back: the CPU may re-request in the same cycle cpu_done is high. There is one IDLE cycle between transactions.
- dma_req rising during a CPU transaction: DMA is granted at the next IDLE, even if cpu_req is high.
- dma_req falling mid-burst: the current cycle is completed if dma_gnt was already high. Return to IDLE next cycle.
- Reset (asynchronous, any state):
  - State goes to IDLE; dma_turn, burst counter, lo/hi are cleared.
  - cpu_done, dma_rvalid, rd_data, eff_addr, mem_we, dma_gnt, busy all go to 0.
  - An in-flight transaction is dropped with no cpu_done.

## Configuration
- MEM_SEQ_ZP_EN defined: cpu_zp = 1 with op 01/10 skips ADH. The high byte is forced to 0x00 and cpu_done arrives 3 cycles after accept.
- MEM_SEQ_ZP_EN undefined: cpu_zp is ignored and all absolute ops take the full ADL/ADH path.

## Structure
- Shared package mosby_pkg holds:
  - state encoding (IDLE..DMA);
  - cpu_op constants OP_FETCH, OP_ABS_RD, OP_ABS_WR;
  - address width 16 and data width 8.
- One sub-module, mem_seq_arb: the IDLE-time DMA/CPU arbitration, dma_turn flag and burst counter. It outputs grant_dma and burst_end.

## Test plan
- Fetch: pc = 0x1234, mem[0x1234] = 0xA9, cpu_op = 00 → mem_addr = 0x1234 for one cycle, then cpu_done with rd_data = 0xA9, 2 cycles after accept.
- Absolute read: pc = 0x0200, mem[0x0201] = 0x34, mem[0x0202] = 0x12, mem[0x1234] = 0x5A → eff_addr = 0x1234, rd_data = 0x5A, cpu_done 4 cycles after accept.
- Absolute write with wrap: pc = 0xFFFF, mem[0x0000] = 0x10, mem[0x0001] = 0x20, cpu_wdata = 0x77 → one cycle with mem_we = 1, mem_addr = 0x2010, mem_wdata = 0x77.
- Arbitration: dma_req held with DMA_MAX_BURST = 4 while cpu_req fetches continuously → alternating pattern of 4 dma_gnt cycles then 1 CPU fetch; no starvation of either side.
- Zero page (MEM_SEQ_ZP_EN): pc = 0x0300, mem[0x0301] = 0x80, cpu_zp = 1, op 01 → data access at 0x0080, cpu_done 3 cycles after accept.
- Reset mid-ADH: rst low asynchronously → busy = 0 and mem_we = 0 immediately; no cpu_done after release; the next fetch completes normally.

Source files
------------

// File: rtl/mosby_pkg.sv
// mosby_pkg: shared state encoding, operation codes and bus widths for the MOSby memory sequencer
package mosby_pkg;
   localparam int ADDR_W = 16;
   localparam int DATA_W = 8;
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ADL, S_ADH, S_DATA, S_DMA} state_t;
   localparam logic [1:0] OP_FETCH  = 2'b00;
   localparam logic [1:0] OP_ABS_RD = 2'b01;
   localparam logic [1:0] OP_ABS_WR = 2'b10;
   function automatic logic is_abs(input logic [1:0] op);
      return op == OP_ABS_RD || op == OP_ABS_WR;
   endfunction
endpackage

// File: rtl/mem_seq_if.sv
// mem_seq_if: CPU request, DMA request and memory port signals of the MOSby sequencer
interface mem_seq_if;
   import mosby_pkg::*;
   logic [ADDR_W-1:0] pc;
   logic              cpu_req;
   logic [1:0]        cpu_op;
   logic              cpu_zp;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_rdy;
   logic              cpu_done;
   logic [DATA_W-1:0] rd_data;
   logic [ADDR_W-1:0] eff_addr;
   logic              dma_req;
   logic [ADDR_W-1:0] dma_addr;
   logic              dma_we;
   logic [DATA_W-1:0] dma_wdata;
   logic              dma_gnt;
   logic              dma_rvalid;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              busy;
   modport slave (
      input  pc, cpu_req, cpu_op, cpu_zp, cpu_wdata, dma_req, dma_addr, dma_we, dma_wdata, mem_rdata,
      output cpu_rdy, cpu_done, rd_data, eff_addr, dma_gnt, dma_rvalid, mem_addr, mem_we, mem_wdata, busy
   );
   modport master (
      output pc, cpu_req, cpu_op, cpu_zp, cpu_wdata, dma_req, dma_addr, dma_we, dma_wdata, mem_rdata,
      input  cpu_rdy, cpu_done, rd_data, eff_addr, dma_gnt, dma_rvalid, mem_addr, mem_we, mem_wdata, busy
   );
endinterface

// File: rtl/mem_seq_arb.sv
// mem_seq_arb: IDLE-time DMA/CPU arbitration with a turn flag against starvation, plus the DMA burst counter
module mem_seq_arb #(
   parameter int DMA_MAX_BURST = 4
) (
   input  logic clk_1,
   input  logic rst,
   input  logic idle,
   input  logic in_dma,
   input  logic dma_req,
   input  logic cpu_req,
   output logic grant_dma,
   output logic accept,
   output logic cpu_rdy,
   output logic burst_end
);
   localparam logic [3:0] BURST_LAST = 4'(DMA_MAX_BURST - 1);
   logic       dma_turn_q, dma_turn_d;
   logic [3:0] cnt_q, cnt_d;
   assign grant_dma = idle && dma_req && (dma_turn_q || !cpu_req);
   assign accept    = idle && cpu_req && !grant_dma;
   assign cpu_rdy   = idle && !(dma_req && dma_turn_q);
   assign burst_end = in_dma && (!dma_req || cnt_q == BURST_LAST);
   // DMA earns the next turn when it waited behind a CPU accept; burst count restarts on every grant
   always_comb begin
      dma_turn_d = grant_dma ? 1'b0 : (accept && dma_req) ? 1'b1 : dma_turn_q;
      cnt_d      = grant_dma ? 4'd0 : in_dma ? cnt_q + 4'd1 : cnt_q;
   end
   // arbitration state registers
   always_ff @(posedge clk_1 or negedge rst) begin
      if (!rst) begin
         dma_turn_q <= 1'b0;
         cnt_q      <= 4'd0;
      end else begin
         dma_turn_q <= dma_turn_d;
         cnt_q      <= cnt_d;
      end
   end
endmodule

// File: rtl/mem_seq.sv
// mem_seq: MOSby memory-access sequencer and DMA arbiter; define MEM_SEQ_ZP_EN to let cpu_zp skip the ADH cycle
module mem_seq
   import mosby_pkg::*;
#(
   parameter int DMA_MAX_BURST = 4
) (
   input  logic     clk_1,
   input  logic     rst,
   mem_seq_if.slave bus
);
`ifdef MEM_SEQ_ZP_EN
   localparam bit ZP_EN = 1'b1;
`else
   localparam bit ZP_EN = 1'b0;
`endif
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d, eff_addr_q, eff_addr_d;
   logic [1:0]        op_q, op_d;
   logic              zp_q, zp_d, cpu_done_q, cpu_done_d, dma_rvalid_q, dma_rvalid_d;
   logic [DATA_W-1:0] wdata_q, wdata_d, lo_q, lo_d, hi_q, hi_d, rd_data_q, rd_data_d;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_we, dma_gnt, idle, in_dma, grant_dma, accept, cpu_rdy, burst_end;
   assign idle   = state_q == S_IDLE;
   assign in_dma = state_q == S_DMA;
   mem_seq_arb #(.DMA_MAX_BURST(DMA_MAX_BURST)) u_arb (
      .clk_1     (clk_1),
      .rst       (rst),
      .idle      (idle),
      .in_dma    (in_dma),
      .dma_req   (bus.dma_req),
      .cpu_req   (bus.cpu_req),
      .grant_dma (grant_dma),
      .accept    (accept),
      .cpu_rdy   (cpu_rdy),
      .burst_end (burst_end)
   );
   assign bus.cpu_rdy    = cpu_rdy;
   assign bus.cpu_done   = cpu_done_q;
   assign bus.rd_data    = rd_data_q;
   assign bus.eff_addr   = eff_addr_q;
   assign bus.dma_gnt    = dma_gnt;
   assign bus.dma_rvalid = dma_rvalid_q;
   assign bus.mem_addr   = mem_addr;
   assign bus.mem_we     = mem_we;
   assign bus.mem_wdata  = mem_wdata;
   assign bus.busy       = !idle;
   // next-state, captured bytes and memory port drive for each sequencer state
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      op_d         = op_q;
      zp_d         = zp_q;
      wdata_d      = wdata_q;
      lo_d         = lo_q;
      hi_d         = hi_q;
      rd_data_d    = rd_data_q;
      eff_addr_d   = eff_addr_q;
      cpu_done_d   = 1'b0;
      dma_rvalid_d = 1'b0;
      mem_addr     = '0;
      mem_we       = 1'b0;
      mem_wdata    = '0;
      dma_gnt      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (grant_dma) state_d = S_DMA;
            else if (accept) begin
               pc_d    = bus.pc;
               op_d    = bus.cpu_op;
               zp_d    = bus.cpu_zp;
               wdata_d = bus.cpu_wdata;
               state_d = is_abs(bus.cpu_op) ? S_ADL : S_FETCH;
            end
         end
         S_FETCH: begin
            mem_addr   = pc_q;
            rd_data_d  = bus.mem_rdata;
            cpu_done_d = 1'b1;
            state_d    = S_IDLE;
         end
         S_ADL: begin
            mem_addr = pc_q + 16'd1;
            lo_d     = bus.mem_rdata;
            hi_d     = '0;
            state_d  = (ZP_EN && zp_q) ? S_DATA : S_ADH;
         end
         S_ADH: begin
            mem_addr = pc_q + 16'd2;
            hi_d     = bus.mem_rdata;
            state_d  = S_DATA;
         end
         S_DATA: begin
            mem_addr   = {hi_q, lo_q};
            eff_addr_d = {hi_q, lo_q};
            mem_we     = op_q == OP_ABS_WR;
            mem_wdata  = op_q == OP_ABS_WR ? wdata_q : '0;
            rd_data_d  = op_q == OP_ABS_WR ? rd_data_q : bus.mem_rdata;
            cpu_done_d = 1'b1;
            state_d    = S_IDLE;
         end
         S_DMA: begin
            mem_addr     = bus.dma_addr;
            mem_we       = bus.dma_we;
            mem_wdata    = bus.dma_wdata;
            dma_gnt      = 1'b1;
            rd_data_d    = bus.dma_we ? rd_data_q : bus.mem_rdata;
            dma_rvalid_d = !bus.dma_we;
            state_d      = burst_end ? S_IDLE : S_DMA;
         end
         default: state_d = S_IDLE;
      endcase
   end
   // sequencer registers; reset drops any in-flight transaction
   always_ff @(posedge clk_1 or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         pc_q         <= '0;
         op_q         <= OP_FETCH;
         zp_q         <= 1'b0;
         wdata_q      <= '0;
         lo_q         <= '0;
         hi_q         <= '0;
         rd_data_q    <= '0;
         eff_addr_q   <= '0;
         cpu_done_q   <= 1'b0;
         dma_rvalid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         op_q         <= op_d;
         zp_q         <= zp_d;
         wdata_q      <= wdata_d;
         lo_q         <= lo_d;
         hi_q         <= hi_d;
         rd_data_q    <= rd_data_d;
         eff_addr_q   <= eff_addr_d;
         cpu_done_q   <= cpu_done_d;
         dma_rvalid_q <= dma_rvalid_d;
      end
   end
endmodule
